// File: rtl/dcm_pkg.sv
// Shared types and helpers for the dcm clock monitor.
package dcm_pkg;

  localparam int NUM_MODES = 8;

  typedef logic [2:0] mode_t;

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEASURE,
    DECODE
  } state_t;

  // Nominal period of mode k, in reference-clock cycles.
  function automatic logic [63:0] expected_period(input logic [63:0] base, input int unsigned k);
    return base << k;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a third flop that
// turns the synchronized level into single-cycle rise/fall pulses.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  // Metastability chain followed by the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/dcm_monitor.sv
// Period/mode checker for the dcm slow clock output.
// Optional duty-cycle check enabled by defining DCM_MON_DUTY_EN.
module dcm_monitor
  import dcm_pkg::*;
#(
  parameter int BASE_PERIOD = 10000000,
  parameter int TOL_SHIFT   = 4,
  parameter int LOCK_COUNT  = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_2_in,
  input  logic [2:0]       prog_exp,
  output logic [2:0]       mode_det,
  output logic             det_valid,
  output logic             no_match,
  output logic             mismatch,
  output logic             locked,
  output logic             clk_lost,
  output logic [CNT_W-1:0] period
`ifdef DCM_MON_DUTY_EN
  ,
  output logic             duty_err
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(expected_period(64'(BASE_PERIOD), 8));
  localparam int LC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LC_W-1:0] LOCK_MAX = LC_W'(LOCK_COUNT);

  state_t           state, state_nxt;
  logic             rise;
  logic [CNT_W-1:0] cnt, quiet_cnt, period_p0;
  logic [LC_W-1:0]  lock_cnt, lock_nxt;
  mode_t            prog_q, dec_mode;
  logic             dec_found, timeout, duty_bad;
  logic [3:0]       dec_res;

  // Saturating increment so no counter can wrap back into a legal window.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == LIMIT) ? c : c + CNT_W'(1);
  endfunction

  // Returns {found, mode}; scanning downward lets the lowest matching mode win.
  function automatic logic [3:0] decode_mode(input logic [CNT_W-1:0] p);
    logic [63:0] pw, exp_p, tol;
    logic [3:0]  res;
    res = '0;
    pw  = 64'(p);
    for (int k = NUM_MODES - 1; k >= 0; k--) begin
      exp_p = expected_period(64'(BASE_PERIOD), unsigned'(k));
      tol   = exp_p >> TOL_SHIFT;
      if ((pw + tol >= exp_p) && (pw <= exp_p + tol)) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

`ifdef DCM_MON_DUTY_EN
  logic fall;
  edge_sync u_sync (.clk(clk), .rst(rst), .din(clk_2_in), .rise(rise), .fall(fall));
`else
  logic fall_unused;
  edge_sync u_sync (.clk(clk), .rst(rst), .din(clk_2_in), .rise(rise), .fall(fall_unused));
`endif

  assign timeout   = (state == MEASURE) && (cnt == LIMIT);
  assign dec_res   = decode_mode(period_p0);
  assign dec_found = dec_res[3];
  assign dec_mode  = dec_res[2:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= WAIT_EDGE;
    else      state <= state_nxt;
  end

  // Next-state logic; a rise during DECODE is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_EDGE: if (rise) state_nxt = MEASURE;
      MEASURE: begin
        if (timeout)   state_nxt = WAIT_EDGE;
        else if (rise) state_nxt = DECODE;
      end
      DECODE:    state_nxt = MEASURE;
      default:   state_nxt = WAIT_EDGE;
    endcase
  end

  // Period counter, idle watchdog and measurement latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      quiet_cnt <= '0;
    end else begin
      case (state)
        WAIT_EDGE: begin
          cnt       <= rise ? CNT_W'(1) : '0;
          quiet_cnt <= rise ? '0 : sat_inc(quiet_cnt);
        end
        MEASURE: begin
          quiet_cnt <= '0;
          if (timeout)   cnt <= '0;
          else if (rise) cnt <= CNT_W'(1);
          else           cnt <= sat_inc(cnt);
        end
        default: begin
          quiet_cnt <= '0;
          cnt       <= sat_inc(cnt);
        end
      endcase
    end
    if (state == MEASURE && rise && !timeout) period_p0 <= cnt;
  end

`ifdef DCM_MON_DUTY_EN
  logic             hi_run;
  logic [CNT_W-1:0] hi_cnt, hi_p0;
  logic [CNT_W:0]   two_hi, per_w, diff;

  // High-time counter from each synchronized rise to the following fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_run <= 1'b0;
      hi_cnt <= '0;
    end else if (rise) begin
      hi_run <= 1'b1;
      hi_cnt <= CNT_W'(1);
    end else if (fall) begin
      hi_run <= 1'b0;
    end else if (hi_run) begin
      hi_cnt <= sat_inc(hi_cnt);
    end
    if (state == MEASURE && rise && !timeout) hi_p0 <= hi_cnt;
  end

  // Duty error when twice the high time strays beyond the period tolerance.
  always_comb begin
    two_hi   = {hi_p0, 1'b0};
    per_w    = {1'b0, period_p0};
    diff     = (two_hi > per_w) ? two_hi - per_w : per_w - two_hi;
    duty_bad = diff > (per_w >> TOL_SHIFT);
  end
`else
  assign duty_bad = 1'b0;
`endif

  // Lock counter advance for the decode in progress.
  always_comb begin
    lock_nxt = lock_cnt;
    if (!dec_found || (dec_mode != prog_exp) || duty_bad) lock_nxt = '0;
    else if (lock_cnt != LOCK_MAX)                       lock_nxt = lock_cnt + LC_W'(1);
  end

  // Status registers; a prog_exp change overrides everything to drop lock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_det  <= '0;
      det_valid <= 1'b0;
      no_match  <= 1'b0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
      clk_lost  <= 1'b0;
      period    <= '0;
      lock_cnt  <= '0;
      prog_q    <= '0;
`ifdef DCM_MON_DUTY_EN
      duty_err  <= 1'b0;
`endif
    end else begin
      det_valid <= (state == DECODE);
      prog_q    <= prog_exp;
      if (state == DECODE) begin
        period   <= period_p0;
        clk_lost <= 1'b0;
        if (dec_found) begin
          mode_det <= dec_mode;
          no_match <= 1'b0;
          mismatch <= (dec_mode != prog_exp);
        end else begin
          no_match <= 1'b1;
        end
        lock_cnt <= lock_nxt;
        locked   <= (lock_nxt == LOCK_MAX);
`ifdef DCM_MON_DUTY_EN
        duty_err <= duty_bad;
`endif
      end else if (timeout || (state == WAIT_EDGE && quiet_cnt == LIMIT)) begin
        clk_lost <= 1'b1;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
      if (prog_exp != prog_q) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcm_monitor.sv
// Self-checking bench for dcm_monitor (BASE_PERIOD=20, TOL_SHIFT=2, LOCK_COUNT=3).
module tb_dcm_monitor;

  localparam int BP = 20;
  localparam int TS = 2;
  localparam int LC = 3;
  localparam int CW = 32;
  localparam int HI = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_2_in = 1'b0;
  logic [2:0]    prog_exp = 3'd0;
  logic [2:0]    mode_det;
  logic          det_valid, no_match, mismatch, locked, clk_lost;
  logic [CW-1:0] period;

  dcm_monitor #(.BASE_PERIOD(BP), .TOL_SHIFT(TS), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .clk_2_in(clk_2_in), .prog_exp(prog_exp),
    .mode_det(mode_det), .det_valid(det_valid), .no_match(no_match),
    .mismatch(mismatch), .locked(locked), .clk_lost(clk_lost), .period(period)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dv_count = 0;

  typedef struct {
    int         per;
    logic [2:0] mode;
    logic       nm, mm, lk;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         per;
    int         n;
    logic [2:0] prog;
    logic [2:0] mode;
    logic       nm, mm, lk;
  } vec_t;
  vec_t vt[10];

  // Reference model state
  bit         armed;
  int         since;
  int         m_cnt;
  logic [2:0] m_mode, m_prog;
  logic       m_nm, m_mm;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    since += n;
  endtask

  task automatic ref_decode(input int p, output bit f, output logic [2:0] k);
    f = 1'b0;
    k = 3'd0;
    for (int m = 0; m < 8; m++) begin
      int e = BP << m;
      int d = p - e;
      if (d < 0) d = -d;
      if (!f && d <= (e >> TS)) begin
        f = 1'b1;
        k = 3'(m);
      end
    end
  endtask

  task automatic model_reset();
    armed  = 1'b0;
    since  = 0;
    m_cnt  = 0;
    m_mode = 3'd0;
    m_nm   = 1'b0;
    m_mm   = 1'b0;
    m_prog = prog_exp;
    sb.delete();
  endtask

  task automatic set_prog(input logic [2:0] v);
    prog_exp = v;
    if (v != m_prog) m_cnt = 0;
    m_prog = v;
  endtask

  task automatic do_rise();
    bit         f;
    logic [2:0] k;
    exp_t       e;
    clk_2_in = 1'b1;
    if (armed) begin
      ref_decode(since, f, k);
      if (f) begin
        m_mode = k;
        m_nm   = 1'b0;
        m_mm   = (k != m_prog);
      end else begin
        m_nm = 1'b1;
      end
      if (!f || k != m_prog) m_cnt = 0;
      else if (m_cnt < LC)   m_cnt++;
      e.per  = since;
      e.mode = m_mode;
      e.nm   = m_nm;
      e.mm   = m_mm;
      e.lk   = (m_cnt == LC);
      sb.push_back(e);
    end
    armed = 1'b1;
    since = 0;
  endtask

  // n periods of length p; each ends with a rise followed by HI high cycles.
  task automatic run_row(input int p, input int n, input logic [2:0] prog);
    set_prog(prog);
    for (int i = 0; i < n; i++) begin
      clk_2_in = 1'b0;
      tick(p - HI);
      do_rise();
      tick(HI);
    end
    clk_2_in = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mode_det"}, int'(mode_det), 0);
    chk({tag, "_det_valid"}, int'(det_valid), 0);
    chk({tag, "_no_match"}, int'(no_match), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_clk_lost"}, int'(clk_lost), 0);
    chk({tag, "_period"}, int'(period), 0);
  endtask

  // Scoreboard: every det_valid pulse must match the next modelled decode.
  always @(negedge clk) begin
    exp_t e;
    if (rst && det_valid) begin
      dv_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_det_valid actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("sb_period", int'(period), e.per);
        chk("sb_mode_det", int'(mode_det), int'(e.mode));
        chk("sb_no_match", int'(no_match), int'(e.nm));
        chk("sb_mismatch", int'(mismatch), int'(e.mm));
        chk("sb_locked", int'(locked), int'(e.lk));
        chk("sb_clk_lost", int'(clk_lost), 0);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dv0;
    int p, m, e, tol, n;
    logic [2:0] pg;

    vt[0] = '{80,   4, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1};
    vt[1] = '{40,   3, 3'd3, 3'd1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{28,   2, 3'd3, 3'd1, 1'b1, 1'b1, 1'b0};
    vt[3] = '{20,   4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{25,   1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{15,   1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[6] = '{30,   1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1000, 1, 3'd6, 3'd6, 1'b0, 1'b0, 1'b0};
    vt[8] = '{50,   1, 3'd6, 3'd1, 1'b0, 1'b1, 1'b0};
    vt[9] = '{51,   1, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0};

    // Reset, then idle input must raise clk_lost after about 5120 cycles
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    model_reset();
    tick(4990);
    chk("idle_clk_lost_early", int'(clk_lost), 0);
    tick(200);
    chk("idle_clk_lost", int'(clk_lost), 1);
    chk("idle_locked", int'(locked), 0);

    // Directed table
    dv0 = dv_count;
    for (int i = 0; i < 10; i++) begin
      run_row(vt[i].per, vt[i].n, vt[i].prog);
      chk($sformatf("row%0d_period", i), int'(period), vt[i].per);
      chk($sformatf("row%0d_mode_det", i), int'(mode_det), int'(vt[i].mode));
      chk($sformatf("row%0d_no_match", i), int'(no_match), int'(vt[i].nm));
      chk($sformatf("row%0d_mismatch", i), int'(mismatch), int'(vt[i].mm));
      chk($sformatf("row%0d_locked", i), int'(locked), int'(vt[i].lk));
      if (i == 0) chk("row0_det_count", dv_count - dv0, 3);
    end

    // Locked at mode 0, then prog_exp moves to 5 and the clock follows at 640
    run_row(20, 4, 3'd0);
    chk("modechg_locked_before", int'(locked), 1);
    set_prog(3'd5);
    tick(1);
    chk("modechg_locked_drop", int'(locked), 0);
    run_row(640, 2, 3'd5);
    chk("modechg_mode_det", int'(mode_det), 5);
    chk("modechg_locked_2dec", int'(locked), 0);
    run_row(640, 1, 3'd5);
    chk("modechg_locked_3dec", int'(locked), 1);
    chk("modechg_mismatch", int'(mismatch), 0);

    // Reset in the middle of a measurement
    run_row(80, 2, 3'd2);
    tick(72);
    do_rise();
    tick(HI);
    clk_2_in = 1'b0;
    tick(45);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    model_reset();
    check_zero("midrst");
    dv0 = dv_count;
    tick(26);
    do_rise();
    tick(HI);
    clk_2_in = 1'b0;
    tick(20);
    chk("midrst_no_det_first_rise", dv_count - dv0, 0);
    tick(52);
    do_rise();
    tick(HI);
    clk_2_in = 1'b0;
    chk("midrst_det_second_rise", dv_count - dv0, 1);
    chk("midrst_mode_det", int'(mode_det), 2);
    chk("midrst_period", int'(period), 80);

    // Randomized periods near and between mode windows
    for (int r = 0; r < 40; r++) begin
      m   = int'($urandom_range(0, 4));
      e   = BP << m;
      tol = e >> TS;
      p   = e - tol - 2 + int'($urandom_range(0, 2 * tol + 4));
      if (p < 16) p = 16;
      pg  = ($urandom_range(0, 1) == 0) ? 3'(m) : 3'($urandom_range(0, 7));
      n   = int'($urandom_range(1, 3));
      run_row(p, n, pg);
    end

    // Clock stops mid-measurement: timeout drops lock
    tick(5300);
    armed = 1'b0;
    chk("timeout_clk_lost", int'(clk_lost), 1);
    chk("timeout_locked", int'(locked), 0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
